// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - sequential unsigned shift-add multiplier with start/done handshake
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       sum;

    // acc_q[WIDTH] is always zero between iterations, so adding the full
    // register is equivalent to adding only its low WIDTH bits.
    assign sum = acc_q + {1'b0, (mplr_q[0] ? mcand_q : {WIDTH{1'b0}})};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplr_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplr_q    <= mplr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplr_d    = mplr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mplr_d  = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = {1'b0, sum[WIDTH:1]};
                mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = {sum, mplr_q[WIDTH-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for seq_shift_add_multiplier
module tb_seq_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start4;
    logic [7:0]  a8, b8;
    logic [3:0]  a4, b4;
    logic        ready8, busy8, done8, ready4, busy4, done4;
    logic [15:0] product8;
    logic [7:0]  product4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_shift_add_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    seq_shift_add_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .product(product4)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One operation on the 8-bit instance; operands are scrambled right after acceptance.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp, input string nm);
        int cyc = 0;
        int bcnt = 0;
        @(negedge clk);
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy8) bcnt++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'd9);
        chk({nm, " busy cycles"}, 64'(bcnt), 64'd8);
        chk({nm, " product"}, 64'(product8), 64'(exp));
        @(negedge clk);
        chk({nm, " ready after"}, {62'd0, ready8, done8}, 64'd2);
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input string nm);
        int cyc = 0;
        @(negedge clk);
        a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        while (!done4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'd5);
        chk({nm, " product"}, 64'(product4), 64'(av) * 64'(bv));
        @(negedge clk);
    endtask

    initial begin
        int dcnt;
        int dtime [3];
        logic [15:0] dprod [3];
        logic [7:0] ra, rb;
        logic [3:0] qa, qb;

        tbl[0] = '{8'd13,  8'd11,  16'd143};
        tbl[1] = '{8'd255, 8'd255, 16'hFE01};
        tbl[2] = '{8'd0,   8'd200, 16'h0000};
        tbl[3] = '{8'd1,   8'hA5,  16'h00A5};
        tbl[4] = '{8'd200, 8'd0,   16'h0000};
        tbl[5] = '{8'd128, 8'd2,   16'd256};

        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset flags8", {61'd0, ready8, busy8, done8}, 64'd4);
        chk("reset product8", 64'(product8), 64'd0);
        chk("reset flags4", {61'd0, ready4, busy4, done4}, 64'd4);
        chk("reset product4", 64'(product4), 64'd0);

        for (int i = 0; i < 6; i++)
            op8(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("vec%0d", i));

        // Second start during RUN must be ignored.
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1 begin a8 = 8'd9; b8 = 8'd9; start8 = 1'b1; end
        @(posedge clk);
        #1 start8 = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("ignored start done count", 64'(dcnt), 64'd1);
        chk("ignored start product", 64'(product8), 64'd12);

        // Reset mid-RUN discards the in-flight result.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun reset flags", {61'd0, ready8, busy8, done8}, 64'd4);
        chk("midrun reset product", 64'(product8), 64'd0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8) dcnt++;
        end
        chk("midrun reset no done", 64'(dcnt), 64'd0);
        op8(8'd7, 8'd6, 16'd42, "after reset");

        // Reset and start together: reset wins.
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd5; start8 = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; start8 = 1'b0; end
        @(negedge clk);
        chk("rst+start stays idle", {61'd0, ready8, busy8, done8}, 64'd4);

        // Start held high: back-to-back ops every 10 cycles, a changed mid-RUN of op 2.
        @(negedge clk);
        a8 = 8'd20; b8 = 8'd30; start8 = 1'b1;
        dcnt = 0;
        for (int c = 1; c <= 60 && dcnt < 3; c++) begin
            @(negedge clk);
            if (dcnt == 1 && c == dtime[0] + 4) a8 = 8'd21;
            if (done8) begin
                dtime[dcnt] = c;
                dprod[dcnt] = product8;
                dcnt++;
            end
        end
        start8 = 1'b0;
        chk("held start done count", 64'(dcnt), 64'd3);
        if (dcnt == 3) begin
            chk("held p0", 64'(dprod[0]), 64'd600);
            chk("held p1", 64'(dprod[1]), 64'd600);
            chk("held p2", 64'(dprod[2]), 64'd630);
            chk("held period01", 64'(dtime[1] - dtime[0]), 64'd10);
            chk("held period12", 64'(dtime[2] - dtime[1]), 64'd10);
        end
        repeat (12) @(negedge clk);
        chk("held start back idle", {62'd0, ready8, busy8}, 64'd2);

        op4(4'd15, 4'd15, "w4 15x15");
        chk("w4 225", 64'(product4), 64'hE1);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            op8(ra, rb, 16'(ra) * 16'(rb), "rand8");
        end
        for (int i = 0; i < 200; i++) begin
            qa = 4'($urandom);
            qb = 4'($urandom);
            op4(qa, qb, "rand4");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
